// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory read bus between the fetch stage and memory.
// The fetch stage (master) raises mem_req with a word address and holds both
// until the memory (slave) answers with mem_ack and mem_rdata.
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
// Holds the PC, reads one instruction word at a time over the req/ack bus and
// buffers returned words in a small prefetch FIFO whose head drives decode.
// A redirect flushes the FIFO and restarts fetch at the new address; a request
// still in flight at that moment is waited out in ABORT and its data dropped.
// Optional feature, enabled by defining FETCH_ALIGN_CHK_EN: a misaligned
// redirect target produces a single address-error marker entry (fetch_exc on
// the head) and halts fetching until the next redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_en,
    input  logic [31:0]  redirect_pc,
    inst_fetch_if.master mem,
    output logic [31:0]  inst_code,
    output logic [31:0]  inst_pc,
`ifdef FETCH_ALIGN_CHK_EN
    output logic         fetch_exc,
`endif
    output logic         inst_valid
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic        started;
    logic [31:0] pc;

    logic        req;
    logic        accept;
    logic        accept_push;
    logic        push_marker;
    logic        fetch_blocked;
    logic        push;
    logic        pop;
    logic        room;
    logic [31:0] push_code;

    logic [31:0]    buf_code [BUF_DEPTH];
    logic [31:0]    buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    // FIFO occupancy decides whether another word may be requested; a full
    // buffer still has room when decode drains the head in the same cycle.
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !stall;
    assign room       = (count < DEPTH) || pop;

    assign mem.mem_addr = {pc[31:2], 2'b00};
    assign mem.mem_req  = req;

    // Next-state and request logic; a redirect overrides everything except
    // the need to wait out a request that memory has not yet answered.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        accept     = 1'b0;
        case (state)
            FETCH: begin
                req = started && !fetch_blocked && !redirect_en && room;
                if (req) begin
                    if (mem.mem_ack) begin
                        accept = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            ABORT: begin
                if (mem.mem_ack) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        if (redirect_en) begin
            if (((state == WAIT) || (state == ABORT)) && !mem.mem_ack) begin
                state_next = ABORT;
            end else begin
                state_next = FETCH;
            end
        end
        if (rst) begin
            req    = 1'b0;
            accept = 1'b0;
        end
    end

    assign accept_push = accept && !redirect_en;
    assign push        = accept_push || push_marker;
    assign push_code   = push_marker ? 32'h0 : mem.mem_rdata;

    // State register plus a start flag that keeps the bus quiet for the
    // first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    // Program counter: reload on redirect, step one word per accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_en) begin
            pc <= redirect_pc;
        end else if (accept_push) begin
            pc <= pc + 32'd4;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk) begin
        if (rst || redirect_en) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // FIFO storage; the entry records the PC that the word was fetched from.
    always_ff @(posedge clk) begin
        if (push && !rst && !redirect_en) begin
            buf_code[wr_ptr] <= push_code;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    assign inst_code = inst_valid ? buf_code[rd_ptr] : 32'h0;
    assign inst_pc   = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

`ifdef FETCH_ALIGN_CHK_EN
    logic exc_pend;
    logic halted;
    logic misaligned;
    logic buf_exc [BUF_DEPTH];

    assign misaligned    = (redirect_pc[1:0] != 2'b00);
    assign fetch_blocked = halted;
    assign push_marker   = exc_pend && (state == FETCH) && !redirect_en && !rst;

    // A misaligned target arms one marker push and halts fetching until the
    // next redirect; the marker waits for any aborted request to drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_pend <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect_en) begin
            exc_pend <= misaligned;
            halted   <= misaligned;
        end else if (push_marker) begin
            exc_pend <= 1'b0;
        end
    end

    // Per-entry address-error flag stored alongside the word.
    always_ff @(posedge clk) begin
        if (push && !rst && !redirect_en) begin
            buf_exc[wr_ptr] <= push_marker;
        end
    end

    assign fetch_exc = inst_valid && buf_exc[rd_ptr];
`else
    assign fetch_blocked = 1'b0;
    assign push_marker   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a small instruction memory
// model. Memory returns the complement of the address as the instruction word,
// after a programmable latency (0 = same-cycle ack). A pop monitor checks that
// decode sees consecutive PCs with matching words, so lost, duplicated or stale
// words show up as mismatches.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        head_exc;

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .mem         (bus),
        .inst_code   (inst_code),
        .inst_pc     (inst_pc),
`ifdef FETCH_ALIGN_CHK_EN
        .fetch_exc   (head_exc),
`endif
        .inst_valid  (inst_valid)
    );

`ifndef FETCH_ALIGN_CHK_EN
    assign head_exc = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] popped [$];
    logic        saw_zero;

    // Memory model state.
    int          lat;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [31:0] addr_l = 32'h0;
    logic        poison;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory latches a request, counts its latency and answers once; it drops
    // any pending request on reset.
    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= 0;
        end else if (busy) begin
            if (bus.mem_ack) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1;
            end
        end else if (bus.mem_req && (lat != 0)) begin
            busy   <= 1'b1;
            cnt    <= 1;
            addr_l <= bus.mem_addr;
        end
    end

    assign bus.mem_ack   = (lat == 0) ? bus.mem_req : (busy && (cnt >= lat));
    assign bus.mem_rdata = poison ? 32'hDEADBEEF :
                           ((lat == 0) ? ~bus.mem_addr : ~addr_l);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive decode-side inputs for the next cycle, just after the clock edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall       = s;
        redirect_en = r;
        redirect_pc = rpc;
        if (r) begin
            exp_pc   = rpc;
            saw_zero = 1'b0;
        end
    endtask

    task automatic resetDut(input int l);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        poison      = 1'b0;
        lat         = l;
        exp_pc      = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        checkOutput(tag, 32'(inst_valid), 32'd1);
    endtask

    task automatic waitBusyStart(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && (cnt == 1) && !bus.mem_ack) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    // Every instruction decode consumes must be the next sequential PC and
    // carry the word memory holds there.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall && !redirect_en && !head_exc) begin
            checkOutput("pop_pc", inst_pc, exp_pc);
            checkOutput("pop_code", inst_code, ~inst_pc);
            popped.push_back(inst_pc);
            if (inst_pc == 32'h0) saw_zero = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        poison      = 1'b0;
        saw_zero    = 1'b0;
        lat         = 1;
        exp_pc      = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then first fetch with a one-cycle memory.
        @(negedge clk);
        checkOutput("rst_req",   32'(bus.mem_req), 32'd0);
        checkOutput("rst_valid", 32'(inst_valid),  32'd0);
        checkOutput("rst_code",  inst_code,        32'h0);
        checkOutput("rst_pc",    inst_pc,          32'h0);
        @(negedge clk);
        checkOutput("t1_req",  32'(bus.mem_req), 32'd1);
        checkOutput("t1_addr", bus.mem_addr,     RESET_PC);
        @(negedge clk);
        checkOutput("t1_lat_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_valid", 32'(inst_valid), 32'd1);
        checkOutput("t1_pc",    inst_pc,         RESET_PC);
        checkOutput("t1_code",  inst_code,       32'h403F_FFFF);
        repeat (10) @(negedge clk);
        checkOutput("t1_npop", 32'(popped.size() >= 3), 32'd1);
        checkOutput("t1_pop0", popped[0], 32'hBFC0_0000);
        checkOutput("t1_pop1", popped[1], 32'hBFC0_0004);
        checkOutput("t1_pop2", popped[2], 32'hBFC0_0008);

        // Same-cycle memory: one instruction per cycle, inst_valid steady.
        resetDut(0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("steady_valid", 32'(inst_valid), 32'd1);
        end

        // Stall for five cycles: buffer fills to two, requests stop.
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2_req_fill", 32'(bus.mem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_req_full", 32'(bus.mem_req), 32'd0);
            checkOutput("t2_valid",    32'(inst_valid),  32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2_req_poppush", 32'(bus.mem_req), 32'd1);
        repeat (6) @(negedge clk);

        // PC wraps from the top of the address space to zero.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        checkOutput("wrap_zero", 32'(saw_zero), 32'd1);

        // Redirect while waiting on a slow memory; the late word is poisoned.
        @(posedge clk);
        #1;
        lat = 3;
        waitBusyStart("t3_wait");
        applyStimulus(1'b0, 1'b1, 32'h8000_0100);
        poison = 1'b1;
        @(negedge clk);
        checkOutput("t3_req_wait", 32'(bus.mem_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t3_abort_req",   32'(bus.mem_req), 32'd0);
        checkOutput("t3_abort_valid", 32'(inst_valid),  32'd0);
        checkOutput("t3_late_ack",    32'(bus.mem_ack), 32'd1);
        @(posedge clk);
        #1;
        poison = 1'b0;
        waitValid("t3_valid");
        checkOutput("t3_pc",   inst_pc,   32'h8000_0100);
        checkOutput("t3_code", inst_code, 32'h7FFF_FEFF);

        // Redirect coinciding with an ack while decode is stalled.
        resetDut(1);
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req && !busy && inst_valid && !bus.mem_ack) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t4_setup", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h0000_1000);
        @(negedge clk);
        checkOutput("t4_ack",       32'(bus.mem_ack), 32'd1);
        checkOutput("t4_pre_valid", 32'(inst_valid),  32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t4_flush", 32'(inst_valid),  32'd0);
        checkOutput("t4_req",   32'(bus.mem_req), 32'd1);
        checkOutput("t4_addr",  bus.mem_addr,     32'h0000_1000);
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitValid("t4_valid");
        checkOutput("t4_pc", inst_pc, 32'h0000_1000);

        // Reset in the middle of a memory wait.
        @(posedge clk);
        #1;
        lat = 3;
        waitBusyStart("t5_wait");
        @(posedge clk);
        #1;
        rst    = 1'b1;
        exp_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        popped.delete();
        @(negedge clk);
        checkOutput("t5_req",   32'(bus.mem_req), 32'd0);
        checkOutput("t5_valid", 32'(inst_valid),  32'd0);
        waitValid("t5_restart");
        checkOutput("t5_pc", inst_pc, RESET_PC);

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned redirect yields one marker and halts fetch.
        applyStimulus(1'b0, 1'b1, 32'h8000_0102);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t6_flush", 32'(inst_valid), 32'd0);
        waitValid("t6_valid");
        checkOutput("t6_exc",  32'(head_exc), 32'd1);
        checkOutput("t6_code", inst_code,     32'h0);
        checkOutput("t6_pc",   inst_pc,       32'h8000_0102);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t6_halt_req", 32'(bus.mem_req), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'h8000_0200);
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitValid("t6_resume");
        checkOutput("t6_resume_pc",  inst_pc,       32'h8000_0200);
        checkOutput("t6_resume_exc", 32'(head_exc), 32'd0);
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
